// File: rtl/ssd_scan_mux_pkg.sv
// Shared definitions for the seven-segment scan multiplexer: anode constant
// and the leading-zero suppression helper.
package ssd_scan_mux_pkg;

    localparam int MAX_DIGITS = 8;

    // Common-anode display: a high anode select means the digit is off.
    localparam logic [MAX_DIGITS-1:0] AN_ALL_OFF = '1;

    typedef logic [3:0] nibble_t;

    // Bit i set means digit i is a leading zero and must stay dark.
    // Digit 0 is never suppressed, so a zero word still shows a single "0".
    function automatic logic [MAX_DIGITS-1:0] lz_mask(input logic [4*MAX_DIGITS-1:0] word,
                                                      input int num_digits);
        logic [MAX_DIGITS-1:0] mask;
        logic                  all_zero;
        mask     = '0;
        all_zero = 1'b1;
        for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
            if (i < num_digits) begin
                all_zero = all_zero && (word[4*i +: 4] == 4'h0);
                mask[i]  = all_zero;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/ssd_scan_mux_if.sv
// Pipeline-side and decoder-side signals of the scan multiplexer.
interface ssd_scan_mux_if #(
    parameter int NUM_DIGITS = 8
);
    logic [4*NUM_DIGITS-1:0] data_in;
    logic                    load;
    logic                    enable;
    logic [3:0]              nibble;
    logic [NUM_DIGITS-1:0]   an_n;
    logic                    blank;
    logic [2:0]              digit_idx;

    modport master (
        output data_in, load, enable,
        input  nibble, an_n, blank, digit_idx
    );

    modport slave (
        input  data_in, load, enable,
        output nibble, an_n, blank, digit_idx
    );
endinterface

// File: rtl/ssd_prescaler.sv
// Terminal-count counter: counts 0..TERMINAL-1 while enabled and pulses tick
// on the wrap cycle; holds its count while disabled.
module ssd_prescaler #(
    parameter int  TERMINAL = 50000,
    localparam int CW       = (TERMINAL > 1) ? $clog2(TERMINAL) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    output logic          tick,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] LAST = CW'(TERMINAL - 1);

    assign tick = enable && (count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (enable) begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ssd_scan_mux.sv
// Time-multiplexed scanner for a common-anode seven-segment display with
// dead time between slots and optional leading-zero blanking.
module ssd_scan_mux
    import ssd_scan_mux_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int PRESCALE    = 50000,
    parameter int DEAD_CYCLES = 16,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    ssd_scan_mux_if.slave bus
);

    localparam int                    CW     = $clog2(PRESCALE);
    localparam logic [NUM_DIGITS-1:0] AN_OFF = AN_ALL_OFF[NUM_DIGITS-1:0];
    localparam logic [2:0]            LAST_IDX = 3'(NUM_DIGITS - 1);

    logic [4*NUM_DIGITS-1:0] shadow;
    logic [4*MAX_DIGITS-1:0] shadow_ext;
    logic [MAX_DIGITS-1:0]   supp_mask;
    logic [CW-1:0]           cnt;
    logic                    slot_tick;
    logic [2:0]              idx;

    logic                    blank_d;
    nibble_t                 nibble_d;
    logic [NUM_DIGITS-1:0]   an_sel;

    nibble_t                 nibble_q;
    logic [NUM_DIGITS-1:0]   an_n_q;
    logic                    blank_q;
    logic [2:0]              digit_idx_q;

    ssd_prescaler #(
        .TERMINAL (PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (bus.enable),
        .tick   (slot_tick),
        .count  (cnt)
    );

    // The shadow register accepts loads regardless of enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
        end else if (bus.load) begin
            shadow <= bus.data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (slot_tick) begin
            idx <= (idx == LAST_IDX) ? 3'd0 : idx + 3'd1;
        end
    end

    // Next-slot output values, taken from the pre-edge counter, index and shadow.
    always_comb begin
        shadow_ext = 32'(shadow);
        supp_mask  = BLANK_LZ ? lz_mask(shadow_ext, NUM_DIGITS) : '0;
        nibble_d   = shadow_ext[{idx, 2'b00} +: 4];
        blank_d    = !bus.enable || (cnt < CW'(DEAD_CYCLES)) || supp_mask[idx];
        an_sel     = ~(NUM_DIGITS'(1) << idx);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nibble_q    <= '0;
            an_n_q      <= AN_OFF;
            blank_q     <= 1'b1;
            digit_idx_q <= '0;
        end else begin
            nibble_q    <= nibble_d;
            an_n_q      <= blank_d ? AN_OFF : an_sel;
            blank_q     <= blank_d;
            digit_idx_q <= idx;
        end
    end

    assign bus.nibble    = nibble_q;
    assign bus.an_n      = an_n_q;
    assign bus.blank     = blank_q;
    assign bus.digit_idx = digit_idx_q;

endmodule
